// File: rtl/ifetch_prefetch_if.sv
// Program-memory read bus: fetch drives the address,
// memory answers with the word combinationally.
interface RdBusInterface #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] Addr;
  logic [INST_WIDTH-1:0] RdData;

  modport master (output Addr, input RdData);
  modport slave  (input Addr, output RdData);
endinterface

// File: rtl/ifetch_prefetch.sv
// Fetch stage: PC, prefetch FIFO and decode handshake.
// Define IFETCH_BYPASS_EN to forward the word straight to decode when empty.
module ifetch_prefetch #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  RdBusInterface.master         io_PgmBus,
  input  logic                  i_Redirect,
  input  logic [ADDR_WIDTH-1:0] i_RedirectAddr,
  output logic                  o_InstValid,
  output logic [INST_WIDTH-1:0] o_Inst,
  output logic [ADDR_WIDTH-1:0] o_InstPC,
  input  logic                  i_InstReady
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [INST_WIDTH-1:0] inst;
  } fetch_ent_t;

  fetch_ent_t            fifo [DEPTH];
  logic [ADDR_WIDTH-1:0] pc;
  logic [PW-1:0]         wptr;
  logic [PW-1:0]         rptr;
  logic [CW-1:0]         count;
  logic                  empty;
  logic                  full;
  logic                  pop;
  logic                  push;
  logic                  bypass;
  logic                  adv;

  assign io_PgmBus.Addr = pc;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

`ifdef IFETCH_BYPASS_EN
  assign bypass = empty & ~i_Redirect & i_InstReady;
`else
  assign bypass = 1'b0;
`endif

  assign pop  = ~empty & i_InstReady & ~i_Redirect;
  assign push = ~i_Redirect & ~bypass & (~full | pop);
  assign adv  = push | bypass;

  always_ff @(posedge i_Clock) begin
    if (!i_Reset) begin
      pc    <= RESET_ADDR;
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
    end else if (i_Redirect) begin
      pc    <= {i_RedirectAddr[ADDR_WIDTH-1:2], 2'b00};
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
    end else begin
      if (adv)  pc   <= pc + ADDR_WIDTH'(4);
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: outputs are gated by the count.
  always_ff @(posedge i_Clock) begin
    if (i_Reset && push)
      fifo[wptr] <= '{pc: pc, inst: io_PgmBus.RdData};
  end

  always_comb begin
    o_InstValid = ~empty;
    o_Inst      = '0;
    o_InstPC    = '0;
    if (!empty) begin
      o_Inst   = fifo[rptr].inst;
      o_InstPC = fifo[rptr].pc;
    end else if (bypass) begin
      o_InstValid = 1'b1;
      o_Inst      = io_PgmBus.RdData;
      o_InstPC    = pc;
    end
  end

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Random and directed stimulus against a queue-based
// model of the fetch stage.
module tb_ifetch_prefetch;

  localparam int DEPTH = 4;
  localparam logic [31:0] RST_PC = 32'h0;
`ifdef IFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic        clk;
  logic        rst_n;
  logic        redir;
  logic [31:0] raddr;
  logic        ready;
  logic        valid;
  logic [31:0] inst;
  logic [31:0] ipc;

  int n_checks;
  int n_errors;

  ent_t        q[$];
  logic [31:0] mpc;

  RdBusInterface #(.ADDR_WIDTH(32), .INST_WIDTH(32)) bus ();

  function automatic logic [31:0] memword(input logic [31:0] a);
    return 32'h1000 + (a >> 2);
  endfunction

  assign bus.RdData = memword(bus.Addr);

  ifetch_prefetch #(
    .ADDR_WIDTH(32),
    .INST_WIDTH(32),
    .DEPTH(DEPTH),
    .RESET_ADDR(RST_PC)
  ) dut (
    .i_Clock(clk),
    .i_Reset(rst_n),
    .io_PgmBus(bus),
    .i_Redirect(redir),
    .i_RedirectAddr(raddr),
    .o_InstValid(valid),
    .o_Inst(inst),
    .o_InstPC(ipc),
    .i_InstReady(ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One cycle: drive, compare before the edge, advance the model.
  task automatic step(input logic r, input logic rd,
                      input logic [31:0] ra, input logic rdy,
                      input bit do_chk);
    logic        ev;
    logic [31:0] ei;
    logic [31:0] ep;
    bit          byp;
    rst_n = r;
    redir = rd;
    raddr = ra;
    ready = rdy;
    @(negedge clk);
    byp = BYP && q.size() == 0 && rdy && !rd;
    ev = 1'b0;
    ei = '0;
    ep = '0;
    if (q.size() > 0) begin
      ev = 1'b1;
      ei = q[0].inst;
      ep = q[0].pc;
    end else if (byp) begin
      ev = 1'b1;
      ei = memword(mpc);
      ep = mpc;
    end
    if (do_chk) begin
      chk("addr", bus.Addr, mpc);
      chk("valid", {31'b0, valid}, {31'b0, ev});
      chk("inst", inst, ei);
      chk("pc", ipc, ep);
    end
    if (!r) begin
      q.delete();
      mpc = RST_PC;
    end else if (rd) begin
      q.delete();
      mpc = ra & 32'hFFFF_FFFC;
    end else if (byp) begin
      mpc = mpc + 32'd4;
    end else begin
      if (q.size() > 0 && rdy) void'(q.pop_front());
      if (q.size() < DEPTH) begin
        q.push_back('{pc: mpc, inst: memword(mpc)});
        mpc = mpc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    mpc = RST_PC;
    rst_n = 1'b0;
    redir = 1'b0;
    raddr = '0;
    ready = 1'b0;
    @(posedge clk);
    #1;
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    // Free run from reset.
    repeat (12) step(1'b1, 1'b0, '0, 1'b1, 1'b1);
    // Stall until full, then drain with simultaneous push/pop.
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    repeat (10) step(1'b1, 1'b0, '0, 1'b0, 1'b1);
    chk("full_addr", bus.Addr, 32'h10);
    chk("full_head", inst, 32'h1000);
    repeat (12) step(1'b1, 1'b0, '0, 1'b1, 1'b1);
    // Redirect with three entries buffered.
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    repeat (3) step(1'b1, 1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 32'h203, 1'b1, 1'b1);
    chk("redir_addr", bus.Addr, 32'h200);
    repeat (4) step(1'b1, 1'b0, '0, 1'b1, 1'b1);
    // Address wrap at the top of memory.
    step(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
    repeat (6) step(1'b1, 1'b0, '0, 1'b1, 1'b1);
    // Back-to-back redirects.
    step(1'b1, 1'b1, 32'h40, 1'b1, 1'b1);
    step(1'b1, 1'b1, 32'h81, 1'b1, 1'b1);
    repeat (3) step(1'b1, 1'b0, '0, 1'b1, 1'b1);
    // Mid-stream reset with two entries buffered.
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    repeat (2) step(1'b1, 1'b0, '0, 1'b0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    chk("rst_addr", bus.Addr, RST_PC);
    chk("rst_valid", {31'b0, valid}, 32'h0);
    repeat (6) step(1'b1, 1'b0, '0, 1'b1, 1'b1);
    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic        r;
      logic        rd;
      logic [31:0] ra;
      r  = ($urandom_range(0, 99) != 0);
      rd = ($urandom_range(0, 19) == 0);
      ra = ($urandom_range(0, 3) == 0) ?
           (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      step(r, rd, ra, ($urandom_range(0, 9) < 7), 1'b1);
    end
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ifetch_prefetch.md
Name: ifetch_prefetch

Overview:
- Instruction fetch stage that drives the program-memory read bus and sits directly upstream of decode.
- Holds the fetch PC and issues one 32-bit word read per cycle; program memory answers combinationally in the same cycle.
- Buffers fetched words with their PCs in a small FIFO and presents them to decode over a valid/ready handshake.
- Handles control-flow redirects by flushing the FIFO and reloading the PC.

Parameters:
- ADDR_WIDTH, 32, program address width in bits.
- INST_WIDTH, 32, instruction width in bits.
- DEPTH, 4, prefetch FIFO entries; power of two, 2..16.
- RESET_ADDR, 0, fetch PC value after reset.

Ports:
- i_Clock  in  1  single clock; all state updates on the rising edge.
- i_Reset  in  1  synchronous, active-low reset.
- io_PgmBus  master  RdBusInterface  drives Addr[ADDR_WIDTH-1:0]; samples RdData[INST_WIDTH-1:0], which is valid in the same cycle.
- i_Redirect  in  1  flush and reload the PC (branch, jump or trap).
- i_RedirectAddr  in  ADDR_WIDTH  new fetch address.
- o_InstValid  out  1  o_Inst and o_InstPC are valid.
- o_Inst  out  INST_WIDTH  instruction at the FIFO head.
- o_InstPC  out  ADDR_WIDTH  address of o_Inst.
- i_InstReady  in  1  decode accepts the head entry this cycle.

Behaviour:
- Reset (i_Reset=0 at an edge), including mid-operation:
  - PC=RESET_ADDR; FIFO count=0; read/write pointers=0.
  - o_InstValid=0, o_Inst=0, o_InstPC=0 from the following cycle.
  - Any in-flight handshake is dropped.
- io_PgmBus.Addr = PC at all times (combinational from the PC register).
- Pop: pop = o_InstValid & i_InstReady & ~i_Redirect.
- Push: push = ~i_Redirect & (count<DEPTH | pop).
  - On push: store {PC, RdData} at the write pointer; PC <= PC+4.
  - Addition is modulo 2^ADDR_WIDTH, so 0xFFFFFFFC wraps to 0x00000000.
- Full (count==DEPTH) with no pop: no push; PC holds; Addr stays stable.
- Full with pop: push and pop in the same cycle; count unchanged.
- Empty: o_InstValid=0; i_InstReady is ignored.
- Latency: a word fetched in cycle N appears at o_Inst in cycle N+1 at the earliest (non-bypass build).
- Redirect (takes priority over everything except reset):
  - FIFO is flushed, count=0, and any pop that cycle is discarded.
  - PC <= {i_RedirectAddr[ADDR_WIDTH-1:2], 2'b00}; the low bits are forced to zero.
  - o_InstValid=0 in the cycle after the redirect.
  - The first word from the new address is fetched in that cycle and becomes visible one cycle later.
- Back-to-back redirects: the last one wins; nothing is pushed while i_Redirect=1.
- Pointers wrap modulo DEPTH. count is a DEPTH-range counter (0..DEPTH inclusive) so full and empty are distinguishable.
- o_Inst/o_InstPC must remain stable while o_InstValid=1 and i_InstReady=0.

Optional Feature:
IFETCH_BYPASS_EN:
- Defined: when the FIFO is empty, there is no redirect, and i_InstReady=1, the word read this cycle goes straight to the outputs.
  - o_InstValid=1, o_Inst=RdData, o_InstPC=PC, all combinationally.
  - The word is consumed without a FIFO write; PC advances by 4.
  - If i_InstReady=0, the word is written to the FIFO as normal.
- Undefined: outputs come from the FIFO head only; minimum latency is 1 cycle.

Test Plan:
- Reset then free-run, RESET_ADDR=0x0, memory word n = 0x1000+n, i_InstReady=1 -> o_InstPC sequence 0x0, 0x4, 0x8, … one per cycle; o_Inst=0x1000, 0x1001, …; first o_InstValid=1 in cycle 2 after reset release (cycle 1 with IFETCH_BYPASS_EN).
- i_InstReady=0 for 10 cycles -> exactly DEPTH=4 pushes; Addr holds at 0x10; head stays {0x0, 0x1000}. Release ready -> entries 0x0–0xC drain, then 0x10 continues with no gap.
- Full FIFO, then i_InstReady=1 -> simultaneous push and pop each cycle; count stays 4; no duplicated or skipped PC.
- Redirect to 0x203 while 3 entries are buffered and i_InstReady=1 -> next cycle o_InstValid=0, Addr=0x200; following cycle o_InstPC=0x200; buffered entries never appear.
- PC=0xFFFFFFF8 free-running -> PCs 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
- Assert i_Reset=0 mid-stream with 2 entries buffered -> next cycle o_InstValid=0, Addr=RESET_ADDR; on release, fetch restarts cleanly from RESET_ADDR.
